// File: rtl/rf_arb_pkg.sv
// Shared widths, entry type and decode helper for the register-file write arbiter.
package rf_arb_pkg;

    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREGS  = 2 ** ADDR_W;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_entry_t;

    function automatic logic [NREGS-1:0] onehot_dec(input logic [ADDR_W-1:0] addr);
        logic [NREGS-1:0] dec;
        dec       = '0;
        dec[addr] = 1'b1;
        return dec;
    endfunction

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// Requester handshakes, RF write port and hazard outputs of the write arbiter.
interface rf_wr_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);

    logic                 req0_valid;
    logic                 req0_ready;
    logic [ADDR_W-1:0]    req0_addr;
    logic [DATA_W-1:0]    req0_data;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [ADDR_W-1:0]    req1_addr;
    logic [DATA_W-1:0]    req1_data;
    logic                 rf_we;
    logic [ADDR_W-1:0]    rf_a3;
    logic [DATA_W-1:0]    rf_wd3;
    logic [2**ADDR_W-1:0] pending;
    logic [1:0]           grant;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  rf_we, rf_a3, rf_wd3, pending, grant
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output rf_we, rf_a3, rf_wd3, pending, grant
    );

endinterface

// File: rtl/rf_wr_slot.sv
// One-entry writeback holding slot; refillable in the cycle it drains.
module rf_wr_slot #(
    parameter int unsigned ADDR_W    = rf_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W    = rf_arb_pkg::DATA_W,
    parameter bit          DROP_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              drain,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept;
    logic              discard;

    always_comb begin
        in_ready = ~valid_q | drain;
        accept   = in_valid & in_ready;
        // Writes to x0 complete the handshake but never occupy the slot.
        discard  = DROP_ZERO && (in_addr == '0);
        valid_d  = valid_q & ~drain;
        addr_d   = addr_q;
        data_d   = data_q;
        if (accept && !discard) begin
            valid_d = 1'b1;
            addr_d  = in_addr;
            data_d  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_addr  = addr_q;
    assign out_data  = data_q;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Round-robin arbiter sharing the RF write port between ALU and load writeback,
// with a pending-write bitmap for hazard detection.
module rf_wr_arbiter #(
    parameter int unsigned ADDR_W    = rf_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W    = rf_arb_pkg::DATA_W,
    parameter bit          DROP_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    rf_wr_arbiter_if.slave  bus
);

    localparam int unsigned NR     = 2 ** ADDR_W;
    localparam logic        PTR_S0 = 1'b0;
    localparam logic        PTR_S1 = 1'b1;

    logic [1:0]        s_valid;
    logic [ADDR_W-1:0] s_addr [2];
    logic [DATA_W-1:0] s_data [2];
    logic [1:0]        grant;
    logic              ptr_q, ptr_d;
    logic              contested;
    logic [NR-1:0]     pend;

    rf_wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DROP_ZERO(DROP_ZERO)) u_slot0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.req0_valid),
        .in_ready  (bus.req0_ready),
        .in_addr   (bus.req0_addr),
        .in_data   (bus.req0_data),
        .drain     (grant[0]),
        .out_valid (s_valid[0]),
        .out_addr  (s_addr[0]),
        .out_data  (s_data[0])
    );

    rf_wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DROP_ZERO(DROP_ZERO)) u_slot1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.req1_valid),
        .in_ready  (bus.req1_ready),
        .in_addr   (bus.req1_addr),
        .in_data   (bus.req1_data),
        .drain     (grant[1]),
        .out_valid (s_valid[1]),
        .out_addr  (s_addr[1]),
        .out_data  (s_data[1])
    );

    always_comb begin
        contested = s_valid[0] & s_valid[1];
        if (contested) begin
            grant = (ptr_q == PTR_S0) ? 2'b01 : 2'b10;
        end else begin
            grant = s_valid;
        end
        // The pointer only moves when a choice was actually made.
        ptr_d = contested ? ((ptr_q == PTR_S0) ? PTR_S1 : PTR_S0) : ptr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= PTR_S0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    always_comb begin
        bus.rf_we  = |grant;
        bus.rf_a3  = '0;
        bus.rf_wd3 = '0;
        if (grant[0]) begin
            bus.rf_a3  = s_addr[0];
            bus.rf_wd3 = s_data[0];
        end else if (grant[1]) begin
            bus.rf_a3  = s_addr[1];
            bus.rf_wd3 = s_data[1];
        end
        bus.grant = grant;
    end

    always_comb begin
        pend = '0;
        if (s_valid[0]) pend[s_addr[0]] = 1'b1;
        if (s_valid[1]) pend[s_addr[1]] = 1'b1;
        bus.pending = pend;
    end

endmodule

// File: doc/rf_wr_arbiter.md
Name: rf_wr_arbiter

Overview:
- Shares the single register-file write port (WE3/A3/WD3 of RF) between two writeback requesters. Requester 0 is the ALU writeback; requester 1 is the load/memory writeback.
- Each requester gets a one-entry holding slot with a valid/ready handshake.
- Slots are served round-robin when both are occupied.
- Exports a pending-write bitmap that hazard/stall logic uses to block reads of registers whose data has not yet reached RF.

Parameters:
- ADDR_W, 5, register address width (32 registers)
- DATA_W, 32, write data width
- DROP_ZERO, 1, when 1 writes to address 0 are accepted and discarded (never reach RF)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- req0_valid  in  1  requester 0 has a write
- req0_ready  out  1  requester 0 write accepted this cycle when valid&ready
- req0_addr  in  ADDR_W  requester 0 destination register
- req0_data  in  DATA_W  requester 0 write data
- req1_valid, req1_ready, req1_addr, req1_data  same as requester 0, for requester 1
- rf_we  out  1  to RF WE3
- rf_a3  out  ADDR_W  to RF A3
- rf_wd3  out  DATA_W  to RF WD3
- pending  out  2**ADDR_W  bit i set while register i has an accepted, unwritten write
- grant  out  2  one-hot slot driving RF this cycle, 00 when idle

Behaviour:
- Reset (rst low, asynchronous):
  - both slots empty, round-robin pointer selects slot 0 first
  - rf_we=0, rf_a3=0, rf_wd3=0, pending=0, grant=00
  - a reset asserted mid-operation discards slot contents; no RF write occurs in the reset cycle
- Slot n:
  - registers valid, addr, data
  - reqn_ready = ~slot_valid | grant[n], so a slot can be refilled in the same cycle it drains
  - accept at edge k loads the slot
- Arbitration (combinational from slot state):
  - one slot valid: that slot is granted
  - both valid: the slot selected by the pointer is granted; the pointer then toggles to the other slot
  - pointer updates only on a contested grant
- Write path:
  - rf_we = |grant
  - rf_a3 and rf_wd3 are muxed from the granted slot; 0 when idle
  - RF captures the write at the edge ending the grant cycle
  - uncontested latency: accepted at edge k, written into RF at edge k+1
  - worst case: written at edge k+2
- Throughput: one write per cycle total. An uncontested requester can stream back-to-back at one per cycle.
- Address 0 with DROP_ZERO=1:
  - handshake completes (ready as normal) but the slot is not loaded
  - rf_we is never asserted for A3=0
  - pending[0] is always 0
- pending:
  - pending = decode(slot0.addr)&slot0.valid | decode(slot1.addr)&slot1.valid
  - a bit clears the cycle after its write is granted, unless the other slot holds the same address or a new accept refills it
- Same address in both slots: writes are issued in grant order, so the later-granted data is final in RF.
- Requester inputs are sampled only when valid&ready. Requesters hold addr/data stable while valid & ~ready. Deasserting valid without a handshake is permitted and has no effect.

Decomposition:
- Package rf_arb_pkg:
  - ADDR_W, DATA_W, NREGS=2**ADDR_W
  - typedef wr_entry_t {valid, addr, data}
  - function onehot_dec(addr)
- Sub-module rf_wr_slot:
  - one holding slot with handshake, ready generation and zero-address drop
  - instantiated twice
- The top holds the arbiter, round-robin pointer, output mux and pending decode.

Test Plan:
- Reset, then req0 writes addr 6 data 2: req0_ready=1. Next cycle rf_we=1, rf_a3=6, rf_wd3=2, grant=01, pending[6]=1. The following cycle pending[6]=0, and an RF read of A1=6 returns 2.
- Both requesters valid every cycle, addresses 3 (req0) and 4 (req1), 4 writes each: grant alternates 01,10,01,10… starting 01, and each requester sees ready every second cycle.
- req1 writes addr 0 data 0xFFFFFFFF: handshake completes, rf_we stays 0, pending=0, and RF reg 0 reads 0.
- Both slots hold addr 8: req0 data 5 (granted first), req1 data 9. pending[8] stays 1 across both grants, then clears, and RF reg 8 reads 9.
- req0 streams addrs 1..8 with data = addr×10, req1 idle: ready=1 every cycle, one rf_we per cycle in order, and RF regs 1..8 read 10..80.
- Assert rst low asynchronously while both slots are full: rf_we drops to 0 immediately, pending=0, neither write reaches RF, and after release grant order restarts at slot 0.
